// File: rtl/fir_sym_param.sv
// Symmetric odd-tap FIR filter with a run-time coefficient bank.
// Pipeline: delay line -> P1 pre-add/multiply -> P2 accumulate -> P3 round/shift/saturate.
// A sample captured on edge E0 reaches yn_data/yn_valid on edge E3.
module fir_sym_param #(
  parameter int D_WIDTH   = 8,
  parameter int C_WIDTH   = 8,
  parameter int N_TAPS    = 19,
  parameter int O_WIDTH   = 8,
  parameter int OUT_SHIFT = 9,
  parameter int ROUND     = 1,
  localparam int M        = (N_TAPS + 1) / 2,
  localparam int A_W      = (M > 1) ? $clog2(M) : 1
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      in_valid,
  input  logic signed [D_WIDTH-1:0] xn_data,
  input  logic                      clr,
  input  logic                      coef_we,
  input  logic [A_W-1:0]            coef_addr,
  input  logic signed [C_WIDTH-1:0] coef_data,
  output logic                      yn_valid,
  output logic signed [O_WIDTH-1:0] yn_data,
  output logic                      sat_flag
);

  localparam int P_W   = D_WIDTH + C_WIDTH + 1;
  localparam int ACC_W = P_W + $clog2(M);
  // One spare bit so adding the rounding constant can never wrap.
  localparam int R_W   = ACC_W + 1;

  localparam logic signed [R_W-1:0] RND_ADD =
    (ROUND != 0) ? (R_W'(1) << (OUT_SHIFT - 1)) : R_W'(0);
  localparam logic signed [R_W-1:0] SAT_MAX = R_W'((1 <<< (O_WIDTH - 1)) - 1);
  localparam logic signed [R_W-1:0] SAT_MIN = R_W'(-(1 <<< (O_WIDTH - 1)));
  localparam logic [O_WIDTH-1:0] OUT_MAX = {1'b0, {(O_WIDTH - 1){1'b1}}};
  localparam logic [O_WIDTH-1:0] OUT_MIN = {1'b1, {(O_WIDTH - 1){1'b0}}};

  logic signed [D_WIDTH-1:0] x_q [N_TAPS];
  logic signed [D_WIDTH-1:0] x_d [N_TAPS];
  logic signed [C_WIDTH-1:0] h_q [M];
  logic signed [C_WIDTH-1:0] h_d [M];
  logic signed [P_W-1:0]     prod_w [M];
  logic signed [P_W-1:0]     p_q [M];
  logic signed [P_W-1:0]     p_d [M];
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [2:0]                valid_q, valid_d;
  logic                      yn_valid_q, yn_valid_d;
  logic signed [O_WIDTH-1:0] yn_data_q, yn_data_d;
  logic                      sat_flag_q, sat_flag_d;
  logic signed [R_W-1:0]     rnd_sum, shifted;

  // Delay line: flush on clr, shift only on a valid sample, otherwise hold.
  always_comb begin
    x_d = x_q;
    if (clr) begin
      for (int i = 0; i < N_TAPS; i++) x_d[i] = '0;
    end else if (in_valid) begin
      x_d[0] = xn_data;
      for (int i = 1; i < N_TAPS; i++) x_d[i] = x_q[i-1];
    end
  end

  // Coefficient bank: out-of-range addresses are dropped; clr leaves it intact.
  always_comb begin
    h_d = h_q;
    if (coef_we && (int'(coef_addr) < M)) h_d[coef_addr] = coef_data;
  end

  // Pre-add mirrored taps and multiply; the centre tap has no partner.
  genvar gi;
  for (gi = 0; gi < M; gi++) begin : g_tap
    if (gi < M - 1) begin : g_pair
      logic signed [D_WIDTH:0] pre_w;
      assign pre_w      = (D_WIDTH + 1)'(x_q[gi]) + (D_WIDTH + 1)'(x_q[N_TAPS-1-gi]);
      assign prod_w[gi] = P_W'(pre_w) * P_W'(h_q[gi]);
    end else begin : g_centre
      assign prod_w[gi] = P_W'(x_q[gi]) * P_W'(h_q[gi]);
    end
  end

  // P1/P2 data and valid pipeline, all zeroed by clr.
  always_comb begin
    for (int k = 0; k < M; k++) p_d[k] = clr ? '0 : prod_w[k];
    acc_d = '0;
    if (!clr) begin
      for (int k = 0; k < M; k++) acc_d = acc_d + ACC_W'(p_q[k]);
    end
    valid_d = clr ? 3'b000 : {valid_q[1:0], in_valid};
  end

  // P3: round, shift, clamp; output registers hold between valid results.
  always_comb begin
    rnd_sum    = R_W'(acc_q) + RND_ADD;
    shifted    = rnd_sum >>> OUT_SHIFT;
    yn_valid_d = valid_q[2];
    yn_data_d  = yn_data_q;
    sat_flag_d = sat_flag_q;
    if (valid_q[2]) begin
      if (shifted > SAT_MAX) begin
        yn_data_d  = OUT_MAX;
        sat_flag_d = 1'b1;
      end else if (shifted < SAT_MIN) begin
        yn_data_d  = OUT_MIN;
        sat_flag_d = 1'b1;
      end else begin
        yn_data_d  = shifted[O_WIDTH-1:0];
        sat_flag_d = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < N_TAPS; i++) x_q[i] <= '0;
      for (int k = 0; k < M; k++) begin
        h_q[k] <= '0;
        p_q[k] <= '0;
      end
      acc_q      <= '0;
      valid_q    <= '0;
      yn_valid_q <= 1'b0;
      yn_data_q  <= '0;
      sat_flag_q <= 1'b0;
    end else begin
      x_q        <= x_d;
      h_q        <= h_d;
      p_q        <= p_d;
      acc_q      <= acc_d;
      valid_q    <= valid_d;
      yn_valid_q <= yn_valid_d;
      yn_data_q  <= yn_data_d;
      sat_flag_q <= sat_flag_d;
    end
  end

  assign yn_valid = yn_valid_q;
  assign yn_data  = yn_data_q;
  assign sat_flag = sat_flag_q;

endmodule

// File: tb/tb_fir_sym_param.sv
// Directed bench for fir_sym_param with default parameters.
// Expected outputs are scheduled per cycle; every cycle checks yn_valid and,
// between strobes, that yn_data/sat_flag hold.
module tb_fir_sym_param;

  logic       clk;
  logic       n_rst;
  logic       in_valid;
  logic [7:0] xn_data;
  logic       clr;
  logic       coef_we;
  logic [3:0] coef_addr;
  logic [7:0] coef_data;
  logic       yn_valid;
  logic [7:0] yn_data;
  logic       sat_flag;

  fir_sym_param dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .xn_data   (xn_data),
    .clr       (clr),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .yn_valid  (yn_valid),
    .yn_data   (yn_data),
    .sat_flag  (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit auto_chk = 1'b0;

  bit         exp_v [0:1023];
  bit         exp_c [0:1023];
  logic [7:0] exp_d [0:1023];
  bit         exp_s [0:1023];
  bit         hold_ok = 1'b0;
  logic [7:0] hold_d  = 8'h00;
  bit         hold_s  = 1'b0;

  logic [7:0] imp_tab [0:18] = '{8'h02, 8'h00, 8'hfd, 8'hfa, 8'hfb, 8'h00, 8'h09,
                                 8'h14, 8'h1c, 8'h20, 8'h1c, 8'h14, 8'h09, 8'h00,
                                 8'hfb, 8'hfa, 8'hfd, 8'h00, 8'h02};
  logic [7:0] coef_tab [0:9] = '{8'h0a, 8'h00, 8'hf2, 8'he8, 8'heb,
                                 8'h00, 8'h25, 8'h50, 8'h72, 8'h7f};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Advance one clock and check the scheduled expectation for the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (yn_valid === 1'b1) $display("txn cyc=%0d yn_data=%02h sat_flag=%0b", cyc, yn_data, sat_flag);
    if (auto_chk) begin
      check("yn_valid", {7'd0, yn_valid}, {7'd0, exp_v[cyc]});
      if (exp_v[cyc] && exp_c[cyc]) begin
        check("yn_data", yn_data, exp_d[cyc]);
        check("sat_flag", {7'd0, sat_flag}, {7'd0, exp_s[cyc]});
        hold_ok = 1'b1;
        hold_d  = exp_d[cyc];
        hold_s  = exp_s[cyc];
      end else if (exp_v[cyc]) begin
        hold_ok = 1'b0;
      end else if (hold_ok) begin
        check("hold_data", yn_data, hold_d);
        check("hold_sat", {7'd0, sat_flag}, {7'd0, hold_s});
      end
    end
  endtask

  // One input cycle; ev schedules a result 3 edges after the capture edge.
  task automatic drive(input bit v, input logic [7:0] d, input bit c,
                       input bit ev, input bit ec, input logic [7:0] ed, input bit es);
    in_valid = v;
    xn_data  = d;
    clr      = c;
    if (ev) begin
      exp_v[cyc+4] = 1'b1;
      exp_c[cyc+4] = ec;
      exp_d[cyc+4] = ed;
      exp_s[cyc+4] = es;
    end
    tick();
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic wr_coef(input logic [3:0] a, input logic [7:0] d);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_rst = 1'b0; in_valid = 1'b0; xn_data = 8'h00; clr = 1'b0;
    coef_we = 1'b0; coef_addr = 4'd0; coef_data = 8'h00;
    #12;
    check("rst_valid", {7'd0, yn_valid}, 8'h00);
    check("rst_data", yn_data, 8'h00);
    check("rst_sat", {7'd0, sat_flag}, 8'h00);
    n_rst = 1'b1;
    hold_ok = 1'b1; hold_d = 8'h00; hold_s = 1'b0;
    auto_chk = 1'b1;

    // Zero coefficients after reset: 40 strobes of 0x00.
    for (int i = 0; i < 40; i++) drive(1'b1, 8'h7f, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    idle(4);

    // Impulse response; an out-of-range write must be ignored.
    for (int i = 0; i < 10; i++) wr_coef(4'(i), coef_tab[i]);
    wr_coef(4'd15, 8'h7f);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 19; i++)
      drive(1'b1, (i == 0) ? 8'h7f : 8'h00, 1'b0, 1'b1, 1'b1, imp_tab[i], 1'b0);
    idle(4);

    // clr two cycles after an input cancels it; clr+coef_we still writes h[0]=0x14.
    for (int i = 0; i < 5; i++) drive(1'b1, 8'h7f, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    idle(4);
    drive(1'b1, 8'h7f, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    idle(1);
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 8'h14;
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    coef_we = 1'b0;
    drive(1'b1, 8'h7f, 1'b0, 1'b1, 1'b1, 8'h05, 1'b0);
    idle(5);

    // Gapped input 1,0,0,1,1 on an empty history; junk data on idle cycles.
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'h7f, 1'b0, 1'b1, 1'b1, 8'h05, 1'b0);
    drive(1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    drive(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'hfd, 1'b0);
    idle(6);

    // Saturation with all coefficients 0x7f.
    for (int i = 0; i < 10; i++) wr_coef(4'(i), 8'h7f);
    for (int i = 0; i < 25; i++) drive(1'b1, 8'h7f, 1'b0, 1'b1, i >= 20, 8'h7f, 1'b1);
    for (int i = 0; i < 25; i++) drive(1'b1, 8'h80, 1'b0, 1'b1, i >= 20, 8'h80, 1'b1);

    // Coefficient write coincident with a sample, zero taps otherwise.
    for (int i = 0; i < 10; i++) wr_coef(4'(i), 8'h00);
    idle(4);
    for (int i = 0; i < 11; i++) drive(1'b1, 8'h40, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    coef_we = 1'b1; coef_addr = 4'd9; coef_data = 8'h40;
    drive(1'b1, 8'h40, 1'b0, 1'b1, 1'b1, 8'h08, 1'b0);
    coef_we = 1'b0;
    drive(1'b1, 8'h40, 1'b0, 1'b1, 1'b1, 8'h08, 1'b0);
    idle(5);

    // Reset mid-stream with saturated output showing.
    for (int i = 0; i < 10; i++) wr_coef(4'(i), 8'h7f);
    for (int i = 0; i < 25; i++) drive(1'b1, 8'h7f, 1'b0, 1'b1, i >= 20, 8'h7f, 1'b1);
    auto_chk = 1'b0;
    drive(1'b1, 8'h7f, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'h7f, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_valid", {7'd0, yn_valid}, 8'h01);
    check("pre_rst_data", yn_data, 8'h7f);
    check("pre_rst_sat", {7'd0, sat_flag}, 8'h01);
    n_rst = 1'b0;
    #1;
    check("async_rst_valid", {7'd0, yn_valid}, 8'h00);
    check("async_rst_data", yn_data, 8'h00);
    check("async_rst_sat", {7'd0, sat_flag}, 8'h00);
    in_valid = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      exp_v[i] = 1'b0;
      exp_c[i] = 1'b0;
      exp_d[i] = 8'h00;
      exp_s[i] = 1'b0;
    end
    hold_ok = 1'b1; hold_d = 8'h00; hold_s = 1'b0;
    auto_chk = 1'b1;
    // Coefficients were cleared by reset: outputs return to 0x00.
    for (int i = 0; i < 20; i++) drive(1'b1, 8'h7f, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_sym_param.md
# fir_sym_param

Parametrised, run-time-programmable symmetric (linear-phase) FIR filter with odd tap count, valid-qualified input, programmable coefficient bank, rounding and saturation. It is the next generation of the team's fixed 19-tap, 8-bit filter and sits in the same sample datapath between the ADC-side sample source and the downstream 8-bit consumer. It keeps the pre-add / multiply / adder-tree structure and the saturating output. It adds gapped input, coefficient loading without resynthesis, a synchronous flush and a saturation indicator.

## Interface
- D_WIDTH, 8: signed input sample width.
- C_WIDTH, 8: signed coefficient width.
- N_TAPS, 19: tap count. Must be odd and ≥3. M = (N_TAPS+1)/2 unique coefficients.
- O_WIDTH, 8: signed output width.
- OUT_SHIFT, 9: arithmetic right shift applied to the accumulator before saturation. Must be ≥1.
- ROUND, 1: 1 = round half up (add 2^(OUT_SHIFT-1) before the shift); 0 = truncate.

Ports:
- clk  in  1  sole clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  xn_data is valid this cycle.
- xn_data  in  D_WIDTH  signed sample.
- clr  in  1  synchronous flush of sample history and pipeline.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(M)  coefficient index 0..M-1.
- coef_data  in  C_WIDTH  signed coefficient.
- yn_valid  out  1  one-cycle strobe; yn_data carries a new result.
- yn_data  out  O_WIDTH  signed filtered output.
- sat_flag  out  1  result of this yn_valid was clamped.

## Operation
- Delay line x[0..N_TAPS-1] advances only when in_valid=1: x[0]<=xn_data and x[i]<=x[i-1]. It holds otherwise.
- Coefficient bank h[0..M-1]. When coef_we=1 and coef_addr<M, h[coef_addr]<=coef_data. Writes with coef_addr≥M are ignored. Coefficients are retained across clr.
- Stage P1 (registered):
  - For k<M-1: p[k] = (x[k]+x[N_TAPS-1-k]) × h[k]. The pre-add is D_WIDTH+1 bits and the product D_WIDTH+C_WIDTH+1 bits, both sign-extended.
  - Centre tap: p[M-1] = x[M-1] × h[M-1].
- Stage P2 (registered): acc = Σp, full precision. ACC_W = D_WIDTH+C_WIDTH+1+clog2(M), so no internal overflow is possible.
- Stage P3 (registered):
  - s = (acc + (ROUND ? 2^(OUT_SHIFT-1) : 0)) >>> OUT_SHIFT.
  - If s > 2^(O_WIDTH-1)-1, yn_data = max positive and sat_flag = 1.
  - If s < -2^(O_WIDTH-1), yn_data = min negative and sat_flag = 1.
  - Otherwise yn_data = s[O_WIDTH-1:0] and sat_flag = 0.
- A 3-bit valid shift register tracks in_valid through P1, P2 and P3. yn_data and sat_flag update only when the P3 valid bit is set and hold otherwise.
- clr=1:
  - The delay line, all P1/P2 data registers and the valid pipeline are zeroed at the end of that cycle. in_valid in the same cycle is ignored.
  - yn_data and sat_flag hold their values. No yn_valid is produced for samples in flight.
- The filter has no state machine. Behaviour is a free-running pipeline qualified by valid.

## Timing
- Reset values: every output is 0, and the delay line, coefficients, pipeline registers and valid bits are all 0.
- Latency: in_valid=1 in cycle c gives yn_valid=1 in cycle c+3 (three register stages after the delay-line capture edge).
- Throughput: one sample per cycle. Back-to-back in_valid gives back-to-back yn_valid. Gaps in in_valid propagate as identical gaps in yn_valid.
- Coefficient write in cycle c applies to every sample whose in_valid is in cycle ≥ c. Samples with in_valid before c use the old value. This includes coef_we and in_valid in the same cycle.
- clr in cycle c:
  - Cancels yn_valid for samples with in_valid in cycles c-2..c.
  - The first sample accepted after clr sees an all-zero history.
  - clr together with coef_we: the write is still performed.
- Reset asserted mid-stream returns all state, including coefficients, to reset values immediately (asynchronously). No yn_valid is produced for samples in flight.

## Test plan
All scenarios use default parameters.
- Post-reset zero coefficients: 40 valid samples of 0x7f produce 40 yn_valid strobes, each 3 cycles after its input, with yn_data=0x00 and sat_flag=0.
- Impulse response:
  - Load h = 0a,00,f2,e8,eb,00,25,50,72,7f.
  - Drive one sample 0x7f followed by 18 zeros.
  - 19 outputs are required, symmetric about the centre: 0x02,0x00,… with centre (127·127+256)>>9 = 0x20.
- Saturation: all h=0x7f.
  - Constant 0x7f converges to yn_data=0x7f with sat_flag=1.
  - Constant 0x80 converges to yn_data=0x80 with sat_flag=1.
- Gapped input: in_valid pattern 1,0,0,1,1 produces a yn_valid pattern identical but delayed by 3 cycles. yn_data holds between strobes.
- Coefficient write in the same cycle as in_valid: with otherwise-zero taps, write h[9]=0x40 coincident with sample 0x40.
  - That sample's output is (64·64+256)>>9 = 0x08.
  - The preceding sample's output uses the old h[9]=0.
- clr mid-stream and reset mid-stream:
  - clr two cycles after an input cancels its yn_valid, and the next sample's output reflects an empty history.
  - n_rst pulled low mid-stream clears yn_data, yn_valid, sat_flag and coefficients to 0 asynchronously.
